// File: rtl/sar_adc_pkg.sv
// Shared types and constants for the SAR ADC sequencer.
// FSM state enum, default parameters and trial-code helper.
package sar_adc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    CONVERT
  } state_t;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_NCH    = 4;
  localparam int DEF_SETTLE = 4;
  localparam int MAX_WIDTH  = 12;

  // One-hot trial bit n; out-of-range n yields zero.
  function automatic logic [MAX_WIDTH-1:0] trial_code(
    input int unsigned n
  );
    logic [MAX_WIDTH-1:0] one;
    one = {{(MAX_WIDTH-1){1'b0}}, 1'b1};
    return one << n;
  endfunction

endpackage

// File: rtl/sar_cmp_sync.sv
// Two-flop synchroniser for the asynchronous comparator output.
// Ports: clk, rst_n (async active-low), d (async in), q (synced out).
module sar_cmp_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sar_adc_ctrl.sv
// SAR ADC sequencer: sample window, then one settle window per bit.
// Ports: start/ch_sel/scan in, cmp_in async; dac_code, mux_sel,
// sample, busy, done, result, result_ch out.
// Optional auto-scan of all channels: define SAR_ADC_AUTOSCAN_EN.
module sar_adc_ctrl
  import sar_adc_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NCH    = DEF_NCH,
  parameter int SETTLE = DEF_SETTLE,
  parameter int CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CHW-1:0]   ch_sel,
  input  logic             scan,
  input  logic             cmp_in,
  output logic [WIDTH-1:0] dac_code,
  output logic [CHW-1:0]   mux_sel,
  output logic             sample,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [CHW-1:0]   result_ch
);

  localparam int CW = $clog2(SETTLE);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    bit_idx;
  logic [WIDTH-1:0] code;
  logic [WIDTH-1:0] trial_cur;
  logic [WIDTH-1:0] trial_nxt;
  logic [WIDTH-1:0] decided;
  logic             cmp_s;
  logic             last_win;
  logic             last_bit;
  logic             ch_ok;
  logic             go;
  logic             more;

  sar_cmp_sync u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (cmp_in),
    .q    (cmp_s)
  );

  assign ch_ok    = {1'b0, ch_sel} < (CHW+1)'(NCH);
  assign last_win = cnt == CW'(SETTLE - 1);
  assign last_bit = bit_idx == '0;
  assign trial_cur = WIDTH'(trial_code(32'(bit_idx)));
  assign trial_nxt = WIDTH'(trial_code(32'(bit_idx) - 32'd1));
  assign decided  = cmp_s ? code : (code & ~trial_cur);

`ifdef SAR_ADC_AUTOSCAN_EN
  logic scanning;
  assign go   = start && (scan || ch_ok);
  assign more = scanning && (mux_sel != CHW'(NCH - 1));
`else
  logic unused_scan;
  assign unused_scan = scan;
  assign go   = start && ch_ok;
  assign more = 1'b0;
`endif

  assign busy     = state != IDLE;
  assign sample   = state == SAMPLE;
  assign dac_code = code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (go) state_n = SAMPLE;
      SAMPLE:  if (last_win) state_n = CONVERT;
      CONVERT: if (last_win && last_bit)
                 state_n = more ? SAMPLE : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      bit_idx   <= '0;
      code      <= '0;
      mux_sel   <= '0;
      done      <= 1'b0;
      result    <= '0;
      result_ch <= '0;
`ifdef SAR_ADC_AUTOSCAN_EN
      scanning  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (go) begin
`ifdef SAR_ADC_AUTOSCAN_EN
            scanning <= scan;
            mux_sel  <= scan ? '0 : ch_sel;
`else
            mux_sel  <= ch_sel;
`endif
          end
        end
        SAMPLE: begin
          cnt <= last_win ? '0 : cnt + 1'b1;
          if (last_win) begin
            code    <= WIDTH'(trial_code(WIDTH - 1));
            bit_idx <= BW'(WIDTH - 1);
          end
        end
        CONVERT: begin
          cnt <= last_win ? '0 : cnt + 1'b1;
          if (last_win && last_bit) begin
            result    <= decided;
            result_ch <= mux_sel;
            done      <= 1'b1;
            code      <= '0;
            if (more) mux_sel <= mux_sel + 1'b1;
          end else if (last_win) begin
            code    <= decided | trial_nxt;
            bit_idx <= bit_idx - 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Scoreboard bench for sar_adc_ctrl with an ideal comparator model.
// Edge counts: done is seen after edge k+36 when start hits edge k.
module tb_sar_adc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, scan, cmp_in;
  logic [1:0] ch_sel, mux_sel, result_ch;
  logic [7:0] dac_code, result;
  logic       sample, busy, done;

  logic [7:0] vin_tab [4];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] r;
    logic [1:0] ch;
    int         c;
  } exp_t;
  exp_t exp_q[$];

  sar_adc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ch_sel(ch_sel),
    .scan(scan), .cmp_in(cmp_in), .dac_code(dac_code),
    .mux_sel(mux_sel), .sample(sample), .busy(busy), .done(done),
    .result(result), .result_ch(result_ch)
  );

  assign cmp_in = vin_tab[mux_sel] >= dac_code;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] e);
    n_chk++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, e);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(result), 32'hdead);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", 32'(result), 32'(e.r));
        chk("result_ch", 32'(result_ch), 32'(e.ch));
        chk("done_time", cyc, e.c);
        chk("busy_in_done", 32'(busy), 0);
      end
    end
  end

  task automatic wait_to(int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic kick(int ch, output int k);
    @(negedge clk);
    ch_sel = 2'(ch);
    start  = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    chk("sample_hi", 32'(sample), 1);
    chk("busy_hi", 32'(busy), 1);
  endtask

  task automatic conv(int ch, logic [7:0] v, output int k);
    vin_tab[ch] = v;
    kick(ch, k);
    exp_q.push_back('{v, 2'(ch), k + 36});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    chk("drain", exp_q.size(), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_dac", 32'(dac_code), 0);
  endtask

  initial begin
    int k;
    logic [7:0] ff, e;
    ff = 8'hFF;
    rst_n = 1'b0;
    start = 1'b0;
    scan = 1'b0;
    ch_sel = '0;
    foreach (vin_tab[i]) vin_tab[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_dac", 32'(dac_code), 0);
    chk("rst_mux", 32'(mux_sel), 0);
    chk("rst_sample", 32'(sample), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_result_ch", 32'(result_ch), 0);
    rst_n = 1'b1;

    conv(0, 8'hA5, k);
    drain();
    conv(1, 8'h00, k);
    drain();

    conv(0, 8'hFF, k);
    for (int i = 0; i < 8; i++) begin
      wait_to(k + 4 + 4 * i);
      e = ff << (7 - i);
      chk("trial_code", 32'(dac_code), 32'(e));
    end
    drain();

    vin_tab[1] = 8'h11;
    conv(2, 8'h5A, k);
    wait_to(k + 10);
    ch_sel = 2'd1;
    chk("mux_hold_a", 32'(mux_sel), 2);
    wait_to(k + 20);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("mux_hold_b", 32'(mux_sel), 2);
    chk("busy_mid", 32'(busy), 1);
    drain();

    vin_tab[0] = 8'h33;
    kick(0, k);
    exp_q.push_back('{8'h33, 2'd0, k + 36});
    exp_q.push_back('{8'h33, 2'd0, k + 73});
    wait_to(k + 37);
    start = 1'b0;
    chk("b2b_sample", 32'(sample), 1);
    drain();

    vin_tab[3] = 8'hC3;
    kick(3, k);
    @(negedge clk);
    start = 1'b0;
    wait_to(k + 18);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_dac", 32'(dac_code), 0);
    chk("arst_mux", 32'(mux_sel), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_result", 32'(result), 0);
    chk("arst_result_ch", 32'(result_ch), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("arst_idle", 32'(busy), 0);

    conv(3, 8'h3C, k);
    drain();
    repeat (5) @(negedge clk);
    chk("result_hold", 32'(result), 32'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
